output_neuron_update: RTL and testbench
=======================================

# output_neuron_update

Backward-pass companion to the linear output neuron. It takes one training sample (neuron inputs, the neuron's computed output, the target) plus the current weights and bias, and computes the error. It then applies one SGD step, `w[i] += lr*err*x[i]` and `b += lr*err`, in Q3.12 fixed point, with `lr = 2^-LR_SHIFT`. The block sits beside the forward neuron in the training loop and feeds updated parameters back to it.

## Interface
- `NUM_INPUTS`, 2, number of neuron inputs/weights.
- `DATA_WIDTH`, 16, width of every data word (signed Q3.12 at default).
- `FRAC_BITS`, 12, fractional bits of the fixed-point format.
- `LR_SHIFT`, 4, learning rate exponent; the rate is `2^-LR_SHIFT`.

Ports (clock and reset first):
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request; accepted only when `ready`=1.
- `ready`  out  1  high when in IDLE.
- `inputs`  in  signed [DATA_WIDTH-1:0] x NUM_INPUTS  sample inputs `x[i]`.
- `neuron_out`  in  signed DATA_WIDTH  forward-pass output for this sample.
- `target`  in  signed DATA_WIDTH  desired output.
- `weights_in`  in  signed [DATA_WIDTH-1:0] x NUM_INPUTS  current weights.
- `bias_in`  in  signed DATA_WIDTH  current bias.
- `weights_out`  out  signed [DATA_WIDTH-1:0] x NUM_INPUTS  updated weights (registered).
- `bias_out`  out  signed DATA_WIDTH  updated bias (registered).
- `error`  out  signed DATA_WIDTH  saturated `target - neuron_out` (registered).
- `done`  out  1  one-cycle pulse when `weights_out`, `bias_out` and `error` are final.

## Operation
- **FSM states:** IDLE, ERR, UPD, BIAS, DONE. `ready` = (state==IDLE), decoded combinationally.
- **IDLE:** when `start`=1, capture all data inputs into internal registers: `x_r`, `no_r`, `tgt_r`. Load `weights_out` <= `weights_in` and `bias_out` <= `bias_in`. Go to ERR. When `start`=0, stay; all outputs hold.
- **ERR:**
  - `error` <= sat(`tgt_r` - `no_r`). The difference is computed at DATA_WIDTH+1 bits, then clamped to [-2^(W-1), 2^(W-1)-1].
  - Clear index `idx` <= 0. Go to UPD.
- **UPD (one weight per cycle):**
  - `prod` = `error` * `x_r[idx]`, computed at 2*DATA_WIDTH signed.
  - `delta` = `prod` >>> (FRAC_BITS+LR_SHIFT). This is an arithmetic shift, so it rounds toward -inf.
  - `weights_out[idx]` <= sat(`weights_out[idx]` + `delta`). The sum is formed at 2*DATA_WIDTH, then clamped to DATA_WIDTH.
  - `idx` increments each cycle. When `idx` == NUM_INPUTS-1, go to BIAS.
- **BIAS:** `bias_out` <= sat(`bias_out` + (`error` >>> LR_SHIFT)). Go to DONE.
- **DONE:** `done`=1 for this cycle only. Go to IDLE.
- **Ignored inputs:**
  - `start` while not IDLE has no effect.
  - Data inputs outside the accept cycle are ignored; the caller may change them freely after acceptance.
- **Reset** (any state, including mid-update):
  - Next state is IDLE; `idx`=0.
  - `weights_out`, `bias_out` and `error` are all cleared to 0; `done`=0.
  - After the reset edge, `ready`=1.
  - A partially updated weight vector is discarded, not output.
- **Output stability:** outputs hold their final values from DONE until the next accepted `start` or reset.

## Timing
- The accept edge is T, i.e. the edge with `start`=1 and `ready`=1. `ready` drops in the cycle after T.
- `error` is valid after edge T+1.
- `weights_out[i]` is final after edge T+2+i.
- `bias_out` is final after edge T+2+NUM_INPUTS.
- `done` is high during cycle T+3+NUM_INPUTS; with default parameters this is T+5.
- `ready` returns high during cycle T+4+NUM_INPUTS. The earliest next accept is at that edge.
- Throughput: one sample per NUM_INPUTS+4 cycles.
- No combinational path from any data input to any output.

## Test plan
- **Basic step:** `x`=[4096,0], `neuron_out`=0, `target`=4096, weights=[0,0], bias=0 -> `error`=4096, `weights_out`=[256,0], `bias_out`=256, `done` pulse exactly 5 cycles after the accept edge.
- **Negative error / floor rounding:**
  - `x`=[4096,4096], `neuron_out`=4096, `target`=0, weights=[100,100], bias=0 -> `error`=-4096, weights=[-156,-156], bias=-256.
  - Separately, `error`=-1 with `x`=[1,0] -> `weights_out[0]` decrements by 1.
- **Saturation:**
  - `target`=32767, `neuron_out`=-32768 -> `error`=32767.
  - `weights_in[0]`=32700, `x[0]`=4096, `error`=4096 -> `weights_out[0]`=32767.
  - `bias_in`=-32760 with `error`=-32768 -> `bias_out`=-32768.
- **Busy handling:** hold `start`=1 and change `weights_in` every cycle during an update -> results reflect only the values captured at T. A second accept occurs exactly at the edge where `ready` first returns high.
- **Reset mid-operation:** assert `rst` in the UPD cycle -> next cycle shows `weights_out`=0, `bias_out`=0, `error`=0, `done`=0 (no pulse), `ready`=1. A subsequent start runs correctly.
- **NUM_INPUTS=4 parameterization:** random Q3.12 vectors against a bit-exact reference model -> all outputs match, `done` at T+7.

Source files
------------

// File: rtl/output_neuron_update.sv
// output_neuron_update: backward-pass SGD step for a linear output neuron.
// Captures one training sample, computes the saturated error, then updates
// one weight per cycle followed by the bias, all in signed fixed point with
// learning rate 2^-LR_SHIFT. Every output is driven from a register.
module output_neuron_update #(
  parameter int NUM_INPUTS = 2,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 12,
  parameter int LR_SHIFT   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         ready,
  input  logic signed [DATA_WIDTH-1:0] inputs      [NUM_INPUTS],
  input  logic signed [DATA_WIDTH-1:0] neuron_out,
  input  logic signed [DATA_WIDTH-1:0] target,
  input  logic signed [DATA_WIDTH-1:0] weights_in  [NUM_INPUTS],
  input  logic signed [DATA_WIDTH-1:0] bias_in,
  output logic signed [DATA_WIDTH-1:0] weights_out [NUM_INPUTS],
  output logic signed [DATA_WIDTH-1:0] bias_out,
  output logic signed [DATA_WIDTH-1:0] error,
  output logic                         done
);

  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int PW    = 2 * DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ERR  = 3'd1,
    S_UPD  = 3'd2,
    S_BIAS = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                         state_q;
  logic        [IDX_W-1:0]        idx_q;
  logic signed [DATA_WIDTH-1:0]   x_q   [NUM_INPUTS];
  logic signed [DATA_WIDTH-1:0]   no_q;
  logic signed [DATA_WIDTH-1:0]   tgt_q;
  logic signed [DATA_WIDTH-1:0]   w_q   [NUM_INPUTS];
  logic signed [DATA_WIDTH-1:0]   b_q;
  logic signed [DATA_WIDTH-1:0]   err_q;
  logic                           done_q;

  // Wide working copies, sign-extended so no intermediate can wrap
  logic signed [PW-1:0]           tgt_ext, no_ext, err_ext, x_ext, w_ext, b_ext;
  logic signed [PW-1:0]           prod, delta;
  logic signed [DATA_WIDTH-1:0]   err_d, w_upd_d, b_upd_d;

  // Clamp a wide signed value into the DATA_WIDTH signed range
  function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [PW-1:0] v);
    logic signed [PW-1:0] max_v;
    logic signed [PW-1:0] min_v;
    max_v = {{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    min_v = {{(PW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    if (v > max_v) begin
      sat = max_v[DATA_WIDTH-1:0];
    end else if (v < min_v) begin
      sat = min_v[DATA_WIDTH-1:0];
    end else begin
      sat = v[DATA_WIDTH-1:0];
    end
  endfunction

  assign ready       = (state_q == S_IDLE);
  assign weights_out = w_q;
  assign bias_out    = b_q;
  assign error       = err_q;
  assign done        = done_q;

  // Datapath: error, per-index weight update and bias update candidates
  always_comb begin
    tgt_ext = tgt_q;
    no_ext  = no_q;
    err_d   = sat(tgt_ext - no_ext);
    err_ext = err_q;
    x_ext   = x_q[idx_q];
    w_ext   = w_q[idx_q];
    prod    = err_ext * x_ext;
    // Arithmetic shift floors toward -inf, matching the training reference
    delta   = prod >>> (FRAC_BITS + LR_SHIFT);
    w_upd_d = sat(w_ext + delta);
    b_ext   = b_q;
    b_upd_d = sat(b_ext + (err_ext >>> LR_SHIFT));
  end

  // Control FSM with registered outputs; reset discards any partial update
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      err_q   <= '0;
      b_q     <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        w_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            x_q     <= inputs;
            no_q    <= neuron_out;
            tgt_q   <= target;
            w_q     <= weights_in;
            b_q     <= bias_in;
            state_q <= S_ERR;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ERR: begin
          err_q   <= err_d;
          idx_q   <= '0;
          state_q <= S_UPD;
        end
        S_UPD: begin
          w_q[idx_q] <= w_upd_d;
          idx_q      <= idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NUM_INPUTS - 1)) begin
            state_q <= S_BIAS;
          end else begin
            state_q <= S_UPD;
          end
        end
        S_BIAS: begin
          b_q     <= b_upd_d;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_neuron_update.sv
// Scoreboard bench: stimulus pushes expected results computed by an
// arithmetic reference model; monitors pop and compare on every done pulse.
module tb_output_neuron_update;

  localparam int SHIFT_DIV = 1 << (12 + 4);
  localparam int LR_DIV    = 1 << 4;

  typedef struct {
    int err;
    int w[4];
    int b;
    int done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // NUM_INPUTS = 2 instance
  logic                start2;
  logic                ready2, done2;
  logic signed [15:0]  in2 [2];
  logic signed [15:0]  w2_in [2];
  logic signed [15:0]  w2_out [2];
  logic signed [15:0]  no2, tgt2, b2_in, b2_out, err2;

  // NUM_INPUTS = 4 instance
  logic                start4;
  logic                ready4, done4;
  logic signed [15:0]  in4 [4];
  logic signed [15:0]  w4_in [4];
  logic signed [15:0]  w4_out [4];
  logic signed [15:0]  no4, tgt4, b4_in, b4_out, err4;

  exp_t q2[$];
  exp_t q4[$];
  int   last_acc2 = 0;

  output_neuron_update #(.NUM_INPUTS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .ready(ready2),
    .inputs(in2), .neuron_out(no2), .target(tgt2),
    .weights_in(w2_in), .bias_in(b2_in),
    .weights_out(w2_out), .bias_out(b2_out), .error(err2), .done(done2)
  );

  output_neuron_update #(.NUM_INPUTS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .ready(ready4),
    .inputs(in4), .neuron_out(no4), .target(tgt4),
    .weights_in(w4_in), .bias_in(b4_in),
    .weights_out(w4_out), .bias_out(b4_out), .error(err4), .done(done4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int clamp16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // Floor division for positive divisor
  function automatic longint floor_div(input longint p, input longint d);
    longint q;
    q = p / d;
    if (p < 0 && q * d != p) q = q - 1;
    return q;
  endfunction

  function automatic exp_t model(input int n, input int x[4], input int no, input int tgt,
                                 input int w[4], input int b);
    exp_t e;
    e.err = clamp16(longint'(tgt) - longint'(no));
    for (int i = 0; i < 4; i++) begin
      if (i < n) e.w[i] = clamp16(longint'(w[i]) + floor_div(longint'(e.err) * longint'(x[i]), SHIFT_DIV));
      else       e.w[i] = 0;
    end
    e.b = clamp16(longint'(b) + floor_div(longint'(e.err), LR_DIV));
    e.done_cyc = 0;
    return e;
  endfunction

  function automatic logic signed [15:0] rnd16();
    return 16'($urandom);
  endfunction

  // Monitor for the 2-input instance
  always @(negedge clk) begin
    if (!rst && done2) begin
      if (q2.size() == 0) begin
        check("spurious_done2", 1, 0);
      end else begin
        exp_t e;
        e = q2.pop_front();
        check("done2_time", cyc, e.done_cyc);
        check("err2", int'(err2), e.err);
        check("w2_0", int'(w2_out[0]), e.w[0]);
        check("w2_1", int'(w2_out[1]), e.w[1]);
        check("bias2", int'(b2_out), e.b);
      end
    end
  end

  // Monitor for the 4-input instance
  always @(negedge clk) begin
    if (!rst && done4) begin
      if (q4.size() == 0) begin
        check("spurious_done4", 1, 0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        check("done4_time", cyc, e.done_cyc);
        check("err4", int'(err4), e.err);
        for (int i = 0; i < 4; i++) check($sformatf("w4_%0d", i), int'(w4_out[i]), e.w[i]);
        check("bias4", int'(b4_out), e.b);
      end
    end
  end

  task automatic scramble2();
    in2[0] = rnd16(); in2[1] = rnd16(); no2 = rnd16(); tgt2 = rnd16();
    w2_in[0] = rnd16(); w2_in[1] = rnd16(); b2_in = rnd16();
  endtask

  task automatic run2(input int x0, input int x1, input int no, input int tgt,
                      input int w0, input int w1, input int b,
                      input bit hold, input bit busy, input bit chk_gap);
    int   n;
    int   xs[4];
    int   ws[4];
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!ready2 && n < 50) begin
      if (busy) scramble2();
      @(negedge clk);
      n++;
    end
    if (!ready2) check("ready2_wait", int'(ready2), 1);
    in2[0] = 16'(x0); in2[1] = 16'(x1); no2 = 16'(no); tgt2 = 16'(tgt);
    w2_in[0] = 16'(w0); w2_in[1] = 16'(w1); b2_in = 16'(b);
    start2 = 1'b1;
    xs = '{x0, x1, 0, 0};
    ws = '{w0, w1, 0, 0};
    e = model(2, xs, no, tgt, ws, b);
    e.done_cyc = cyc + 1 + 2 + 2;
    q2.push_back(e);
    if (chk_gap) check("accept_gap", (cyc + 1) - last_acc2, 2 + 4);
    last_acc2 = cyc + 1;
    @(negedge clk);
    if (!hold) start2 = 1'b0;
    if (busy) scramble2();
  endtask

  task automatic run4();
    int   n;
    int   xs[4];
    int   ws[4];
    int   no, tgt, b;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!ready4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready4) check("ready4_wait", int'(ready4), 1);
    for (int i = 0; i < 4; i++) begin
      xs[i] = int'(rnd16());
      ws[i] = int'(rnd16());
      in4[i] = 16'(xs[i]);
      w4_in[i] = 16'(ws[i]);
    end
    no = int'(rnd16()); tgt = int'(rnd16()); b = int'(rnd16());
    no4 = 16'(no); tgt4 = 16'(tgt); b4_in = 16'(b);
    start4 = 1'b1;
    e = model(4, xs, no, tgt, ws, b);
    e.done_cyc = cyc + 1 + 4 + 2;
    q4.push_back(e);
    @(negedge clk);
    start4 = 1'b0;
    for (int i = 0; i < 4; i++) in4[i] = rnd16();
  endtask

  initial begin
    int n;
    rst = 1'b1; start2 = 1'b0; start4 = 1'b0;
    scramble2();
    for (int i = 0; i < 4; i++) begin in4[i] = '0; w4_in[i] = '0; end
    no4 = '0; tgt4 = '0; b4_in = '0;
    repeat (3) @(negedge clk);
    // Reset state
    check("rst_ready", int'(ready2), 1);
    check("rst_done", int'(done2), 0);
    check("rst_err", int'(err2), 0);
    check("rst_w0", int'(w2_out[0]), 0);
    check("rst_bias", int'(b2_out), 0);
    check("rst_ready4", int'(ready4), 1);
    rst = 1'b0;

    // Basic step
    run2(4096, 0, 0, 4096, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    // Negative error with floor rounding
    run2(4096, 4096, 4096, 0, 100, 100, 0, 1'b0, 1'b0, 1'b0);
    run2(1, 0, 1, 0, 37, 5, 3, 1'b0, 1'b0, 1'b0);
    // Saturation cases
    run2(4096, 4096, -32768, 32767, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    run2(4096, 0, 0, 4096, 32700, 0, 0, 1'b0, 1'b0, 1'b0);
    run2(0, 0, 0, -32768, 0, 0, -32760, 1'b0, 1'b0, 1'b0);
    // Busy handling: start held, inputs churn, back-to-back accepts
    run2(2048, -4096, 1000, -3000, 500, -700, 42, 1'b1, 1'b1, 1'b0);
    run2(-8192, 12288, -5000, 7000, -1200, 900, -64, 1'b1, 1'b1, 1'b1);
    run2(300, -300, 20000, -20000, 32000, -32000, 5, 1'b0, 1'b1, 1'b1);

    // Reset during the first UPD cycle
    @(negedge clk);
    while (!ready2) @(negedge clk);
    in2[0] = 16'sd4096; in2[1] = 16'sd4096; no2 = '0; tgt2 = 16'sd4096;
    w2_in[0] = 16'sd1000; w2_in[1] = 16'sd1000; b2_in = 16'sd1000;
    start2 = 1'b1;
    @(negedge clk);             // after accept edge: ERR
    start2 = 1'b0;
    @(negedge clk);             // after error edge: UPD
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_w0", int'(w2_out[0]), 0);
    check("mid_rst_w1", int'(w2_out[1]), 0);
    check("mid_rst_bias", int'(b2_out), 0);
    check("mid_rst_err", int'(err2), 0);
    check("mid_rst_done", int'(done2), 0);
    check("mid_rst_ready", int'(ready2), 1);
    repeat (6) @(negedge clk);  // a pulse here would be flagged as spurious
    run2(4096, 0, 0, 4096, 0, 0, 0, 1'b0, 1'b0, 1'b0);

    // Random sweep on both widths
    for (int k = 0; k < 10; k++) begin
      run2(int'(rnd16()), int'(rnd16()), int'(rnd16()), int'(rnd16()),
           int'(rnd16()), int'(rnd16()), int'(rnd16()), 1'b0, 1'b0, 1'b0);
    end
    for (int k = 0; k < 20; k++) run4();

    // Drain the scoreboards with a bound
    n = 0;
    while ((q2.size() != 0 || q4.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_q2", q2.size(), 0);
    check("drain_q4", q4.size(), 0);
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
